// File: rtl/csr_trap_unit_if.sv
// Purpose: pipeline <-> CSR/trap unit bundle.
// Ports (master = core pipeline, slave = csr_trap_unit):
//   csr_en/csr_op/csr_addr/csr_src : CSR access from write-back
//   csr_rdata/csr_illegal          : old CSR value and access fault (combinational)
//   ecall/ebreak/mret/trap_pc      : retiring trap/return instructions
//   instret                        : one instruction retired this cycle
//   irq_timer/irq_ok               : timer interrupt line and interruptible boundary
//   redirect/redirect_pc           : fetch redirect (combinational)
//   irq_enabled                    : registered mstatus.MIE
interface csr_trap_unit_if #(
  parameter int unsigned XLEN = 32
);
  logic            csr_en;
  logic [1:0]      csr_op;
  logic [11:0]     csr_addr;
  logic [XLEN-1:0] csr_src;
  logic [XLEN-1:0] csr_rdata;
  logic            csr_illegal;
  logic            ecall;
  logic            ebreak;
  logic            mret;
  logic [XLEN-1:0] trap_pc;
  logic            instret;
  logic            irq_timer;
  logic            irq_ok;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            irq_enabled;

  modport master (
    output csr_en, csr_op, csr_addr, csr_src, ecall, ebreak, mret, trap_pc,
           instret, irq_timer, irq_ok,
    input  csr_rdata, csr_illegal, redirect, redirect_pc, irq_enabled
  );

  modport slave (
    input  csr_en, csr_op, csr_addr, csr_src, ecall, ebreak, mret, trap_pc,
           instret, irq_timer, irq_ok,
    output csr_rdata, csr_illegal, redirect, redirect_pc, irq_enabled
  );
endinterface

// File: rtl/csr_trap_unit.sv
// Purpose: machine-mode CSR file with single-cycle trap entry / mret and
//          64-bit mcycle/minstret counters for the RV32 core.
// Ports:
//   clock : system clock
//   reset : synchronous, active-high
//   bus   : csr_trap_unit_if.slave (CSR access, trap/return, redirect)
module csr_trap_unit #(
  parameter int unsigned     XLEN        = 32,
  parameter logic [XLEN-1:0] VENDOR_ID   = 32'h79737978,
  parameter logic [XLEN-1:0] ARCH_ID     = 32'd22050499,
  parameter logic [XLEN-1:0] RESET_MTVEC = 32'h0
) (
  input  logic            clock,
  input  logic            reset,
  csr_trap_unit_if.slave  bus
);

  localparam int unsigned CW = 2 * XLEN;

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_MVENDORID = 12'hF11;
  localparam logic [11:0] A_MARCHID   = 12'hF12;
  localparam logic [11:0] A_MIMPID    = 12'hF13;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_RW   = 2'b01;
  localparam logic [1:0] OP_RS   = 2'b10;
  localparam logic [1:0] OP_RC   = 2'b11;

  localparam logic [XLEN-1:0] CAUSE_TIMER  = {1'b1, (XLEN-1)'(7)};
  localparam logic [XLEN-1:0] CAUSE_ECALL  = XLEN'(11);
  localparam logic [XLEN-1:0] CAUSE_EBREAK = XLEN'(3);
  localparam logic [XLEN-1:0] VEC_OFFSET   = XLEN'(28);
  localparam logic [XLEN-1:0] MASK_LO2     = XLEN'(3);
  localparam logic [XLEN-1:0] MASK_B1      = XLEN'(2);

  logic            mie_q, mpie_q, mtie_q;
  logic [XLEN-1:0] mtvec_q, mscratch_q, mepc_q, mcause_q;
  logic [CW-1:0]   mcycle_q, minstret_q;

  logic [XLEN-1:0] old_val, wdata, redirect_pc;
  logic            implemented, modifies, ro_viol, illegal;
  logic            int_pend, trap, csr_we;

  // Combinational CSR read; unimplemented addresses read zero.
  always_comb begin
    old_val     = '0;
    implemented = 1'b1;
    case (bus.csr_addr)
      A_MSTATUS: begin
        old_val[12:11] = 2'b11;
        old_val[7]     = mpie_q;
        old_val[3]     = mie_q;
      end
      A_MIE:                 old_val[7] = mtie_q;
      A_MTVEC:               old_val = mtvec_q;
      A_MSCRATCH:            old_val = mscratch_q;
      A_MEPC:                old_val = mepc_q;
      A_MCAUSE:              old_val = mcause_q;
      A_MIP:                 old_val[7] = bus.irq_timer;
      A_MCYCLE:              old_val = mcycle_q[XLEN-1:0];
      A_MCYCLEH:             old_val = mcycle_q[CW-1:XLEN];
      A_MINSTRET:            old_val = minstret_q[XLEN-1:0];
      A_MINSTRETH:           old_val = minstret_q[CW-1:XLEN];
      A_MVENDORID:           old_val = VENDOR_ID;
      A_MARCHID:             old_val = ARCH_ID;
      A_MIMPID, A_MHARTID:   old_val = '0;
      default:               implemented = 1'b0;
    endcase
  end

  // Zicsr write value.
  always_comb begin
    case (bus.csr_op)
      OP_RW:   wdata = bus.csr_src;
      OP_RS:   wdata = old_val | bus.csr_src;
      OP_RC:   wdata = old_val & ~bus.csr_src;
      default: wdata = old_val;
    endcase
  end

  // RS/RC with a zero source is a pure read and never counts as a write.
  assign modifies = (bus.csr_op != OP_NONE) &&
                    ((bus.csr_op == OP_RW) || (bus.csr_src != '0));
  assign ro_viol  = (bus.csr_addr[11:10] == 2'b11) && modifies;
  assign illegal  = bus.csr_en && (!implemented || ro_viol);

  assign int_pend = mie_q && mtie_q && bus.irq_timer && bus.irq_ok;
  assign trap     = int_pend || bus.ecall || bus.ebreak;
  assign csr_we   = bus.csr_en && modifies && !illegal && !trap && !bus.mret;

  // Redirect target: trap vector (vectored only for interrupts) or mepc.
  always_comb begin
    redirect_pc = mepc_q;
    if (trap) begin
      redirect_pc = mtvec_q & ~MASK_LO2;
      if (int_pend && (mtvec_q[1:0] == 2'b01)) begin
        redirect_pc = redirect_pc + VEC_OFFSET;
      end
    end
  end

  assign bus.csr_rdata   = old_val;
  assign bus.csr_illegal = !reset && illegal;
  assign bus.redirect    = !reset && (trap || bus.mret);
  assign bus.redirect_pc = redirect_pc;
  assign bus.irq_enabled = mie_q;

  // Architectural CSR state: trap > mret > CSR write.
  always_ff @(posedge clock) begin
    if (reset) begin
      mie_q      <= 1'b0;
      mpie_q     <= 1'b0;
      mtie_q     <= 1'b0;
      mtvec_q    <= RESET_MTVEC & ~MASK_B1;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
    end else if (trap) begin
      mepc_q   <= bus.trap_pc & ~MASK_LO2;
      mcause_q <= int_pend  ? CAUSE_TIMER :
                  bus.ecall ? CAUSE_ECALL : CAUSE_EBREAK;
      mpie_q   <= mie_q;
      mie_q    <= 1'b0;
    end else if (bus.mret) begin
      mie_q  <= mpie_q;
      mpie_q <= 1'b1;
    end else if (csr_we) begin
      case (bus.csr_addr)
        A_MSTATUS: begin
          mie_q  <= wdata[3];
          mpie_q <= wdata[7];
        end
        A_MIE:      mtie_q     <= wdata[7];
        A_MTVEC:    mtvec_q    <= wdata & ~MASK_B1;
        A_MSCRATCH: mscratch_q <= wdata;
        A_MEPC:     mepc_q     <= wdata & ~MASK_LO2;
        A_MCAUSE:   mcause_q   <= wdata;
        default:    ;
      endcase
    end
  end

  // Counters: a write to either half replaces that cycle's increment.
  always_ff @(posedge clock) begin
    if (reset) begin
      mcycle_q <= '0;
    end else if (csr_we && (bus.csr_addr == A_MCYCLE)) begin
      mcycle_q <= {mcycle_q[CW-1:XLEN], wdata};
    end else if (csr_we && (bus.csr_addr == A_MCYCLEH)) begin
      mcycle_q <= {wdata, mcycle_q[XLEN-1:0]};
    end else begin
      mcycle_q <= mcycle_q + CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      minstret_q <= '0;
    end else if (csr_we && (bus.csr_addr == A_MINSTRET)) begin
      minstret_q <= {minstret_q[CW-1:XLEN], wdata};
    end else if (csr_we && (bus.csr_addr == A_MINSTRETH)) begin
      minstret_q <= {wdata, minstret_q[XLEN-1:0]};
    end else if (bus.instret) begin
      minstret_q <= minstret_q + CW'(1);
    end
  end

endmodule

// File: doc/csr_trap_unit.md
Name: csr_trap_unit

Overview:
- Machine-mode CSR file with trap sequencing for the single-issue RV32 core.
- Adds the following:
  - Architectural 12-bit CSR addressing.
  - Zicsr RW/RS/RC operations.
  - An ecall/ebreak/timer-interrupt trap entry, and mret return.
  - 64-bit mcycle/minstret counters.
- Sits beside the register file. It is read and written in the write-back stage, and supplies the redirect PC to the fetch stage.

Parameters:
- XLEN, 32, data width of every CSR and datapath port.
- VENDOR_ID, 32'h79737978, value returned by mvendorid.
- ARCH_ID, 32'd22050499, value returned by marchid.
- RESET_MTVEC, 32'h0, reset value of mtvec.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- csr_en  in  1  CSR instruction retiring this cycle
- csr_op  in  2  01 RW, 10 RS, 11 RC, 00 no-op
- csr_addr  in  12  architectural CSR address
- csr_src  in  XLEN  rs1 value or zimm, zero-extended
- csr_rdata  out  XLEN  old value of the addressed CSR (combinational)
- csr_illegal  out  1  unimplemented address, or write to a read-only CSR
- ecall  in  1  ecall retiring
- ebreak  in  1  ebreak retiring
- mret  in  1  mret retiring
- trap_pc  in  XLEN  PC of the retiring instruction
- instret  in  1  one instruction retired this cycle
- irq_timer  in  1  machine timer interrupt line (level)
- irq_ok  in  1  pipeline is at an interruptible boundary
- redirect  out  1  fetch must jump this cycle
- redirect_pc  out  XLEN  jump target
- irq_enabled  out  1  current mstatus.MIE

Behaviour:

Implemented CSRs:
- mstatus 0x300: only MIE[3], MPIE[7] and MPP[12:11] are stored. MPP reads as 2'b11; all other bits read 0.
- mie 0x304: only MTIE[7] is stored.
- mtvec 0x305: bit 1 reads 0. Mode is bits [1:0]: 00 direct, 01 vectored.
- mscratch 0x340: full width.
- mepc 0x341: bits [1:0] read 0.
- mcause 0x342: full width.
- mip 0x344: read-only; MTIP[7] = irq_timer.
- Counters: mcycle/mcycleh 0xB00/0xB80 and minstret/minstreth 0xB02/0xB82.
- Identification, read-only: mvendorid 0xF11, marchid 0xF12, mimpid 0xF13 (reads 0), mhartid 0xF14 (reads 0).

Reset values:
- mstatus: MIE=0, MPIE=0, MPP=11, so it reads 32'h1800.
- mtvec = RESET_MTVEC.
- All other state registers are 0.
- Outputs at reset: redirect=0, csr_illegal=0, irq_enabled=0.

CSR access:
- Read is combinational with zero latency. csr_rdata is valid whenever csr_addr is presented; unimplemented addresses read 0.
- Write value:
  - RW: src.
  - RS: old | src.
  - RC: old & ~src.
- The write commits on the next rising clock edge when csr_en=1 and csr_op!=00.
- csr_illegal=1 when csr_en=1 and either:
  - the address is unimplemented, or
  - csr_addr[11:10]==2'b11, csr_op!=00 and the op is RW or src!=0.
- An illegal access writes nothing.
- RS/RC with src==0 performs no write.

Counters:
- mcycle increments every cycle out of reset.
- minstret increments when instret=1.
- Each counter is 64 bits; the high half is reached via the *h address. Carry from the low half into the high half wraps modulo 2^64.
- A CSR write to either half in a cycle replaces the increment for that counter in that cycle. The other half is held.

Interrupt pending:
- int_pend = mstatus.MIE & mie.MTIE & irq_timer & irq_ok.

Priority within one cycle, highest first:
1. reset
2. int_pend
3. ecall/ebreak
4. mret
5. CSR write

- A trap suppresses a concurrent CSR write and mret.
- mret suppresses a concurrent CSR write.
- If ecall and ebreak are both asserted, ecall wins.

Trap entry (single cycle):
- Combinational outputs in the same cycle:
  - redirect=1.
  - redirect_pc = mtvec base (bits [31:2], {base,2'b00}).
  - If mode=01 and the trap is an interrupt: redirect_pc = base + 4*7.
- Committed at the clock edge:
  - mepc <= trap_pc & ~3.
  - mcause <= one of:
    - 32'h8000_0007 for a timer interrupt,
    - 32'd11 for ecall,
    - 32'd3 for ebreak.
  - MPIE <= MIE, MIE <= 0, MPP <= 11.

mret:
- Combinational: redirect=1, redirect_pc = mepc.
- At the clock edge: MIE <= MPIE, MPIE <= 1.

Other outputs:
- irq_enabled mirrors registered MIE.
- The new MIE value is visible the cycle after the write or trap.

Boundary cases:
- A CSR write to mtvec or mepc in cycle N is used by a trap or mret in cycle N+1, not in cycle N.
- reset asserted mid-trap: all state is forced to reset values and redirect=0 in that cycle.
- irq_timer held high after trap entry: no re-entry, because MIE=0.

Test Plan:
- Reset released, then read 0x300, 0xF11 and 0xF12 -> 32'h1800, 32'h79737978 and 32'd22050499; csr_illegal=0.
- RW 0x305 with 32'h8000_0101, then RS 0x340 with 32'hF0, then RC 0x340 with 32'h30 -> mtvec reads 32'h8000_0101 and mscratch reads 32'hC0; csr_rdata shows the old value on each access.
- mtvec=32'h8000_0000, ecall with trap_pc=32'h8000_0104 -> same-cycle redirect_pc=32'h8000_0000. Next cycle: mepc=32'h8000_0104, mcause=11, mstatus.MIE=0. Then mret -> redirect_pc=32'h8000_0104.
- Set MIE=1, MTIE=1, mtvec=32'h8000_0001; raise irq_timer with irq_ok=1 in the same cycle as an ecall -> interrupt wins; redirect_pc=32'h8000_001C; mcause=32'h8000_0007; MPIE=1; irq_enabled=0 next cycle.
- RW 0xF11, and a read of 0x7C0 -> csr_illegal=1, no state change. Write mcycle=32'hFFFF_FFFF, then run 2 cycles -> mcycleh=1, mcycle=1.
- Assert instret for 5 cycles, asserting reset in the 3rd -> minstret=2 after reset releases, and all CSRs hold reset values.
